// File: rtl/keypad_bcd_fifo.sv
// keypad_bcd_fifo
// Captures one key code per key press from a keypad scanner. Each code is
// converted to two-digit packed BCD and buffered in a DEPTH-entry FIFO that a
// display or host interface drains one value per request.
//
// Ports:
//   clock        - single clock, rising edge
//   reset_n      - asynchronous active-low reset, clears all state
//   code         - key code from scanner, sampled only on a press
//   code_valid   - level, high while a key is held
//   rd_enable    - pop request, sampled each rising edge
//   clr_overflow - synchronous clear of overflow (a new drop wins)
//   BCD          - last popped value, [7:4] tens, [3:0] units
//   bcd_valid    - one-cycle pulse in the cycle BCD updates
//   empty/full   - FIFO occupancy flags
//   count        - occupied entries, 0..DEPTH
//   overflow     - sticky, a press was dropped because the FIFO was full
//
// Handshake: there is no ready path. A pop is performed exactly when
// rd_enable is high at a rising edge and the FIFO is not empty; the popped
// value appears on BCD after that edge with bcd_valid high for one cycle.
// A pop request against an empty FIFO is ignored (no fall-through).
module keypad_bcd_fifo #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  input  logic              rd_enable,
  input  logic              clr_overflow,
  output logic [7:0]        BCD,
  output logic              bcd_valid,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          vld_q;

  logic          press;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [6:0]    code_ext;
  logic [7:0]    bcd_entry;

  // Codes are at most 6 bits (0..63), so a 7-bit zero-extended value is
  // enough for the constant divide/modulo that produce the two digits.
  assign code_ext  = 7'(code);
  assign bcd_entry = {4'(code_ext / 7'd10), 4'(code_ext % 7'd10)};

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // vld_q resets high, so a key still held when reset releases is not seen
  // as a press until it has been let go.
  assign press   = code_valid & ~vld_q;
  assign do_pop  = rd_enable & ~empty;
  // A simultaneous pop frees the slot, so a press into a full FIFO is kept.
  assign do_push = press & (~full | do_pop);
  assign drop    = press & full & ~do_pop;

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= bcd_entry;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q     <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      BCD       <= 8'h00;
      bcd_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      vld_q     <= code_valid;
      bcd_valid <= do_pop;

      if (do_push) wr_ptr <= wr_ptr + 1'b1;

      // When full, wr_ptr equals rd_ptr; the read here sees the old entry
      // because the write above lands only at the end of this edge.
      if (do_pop) begin
        BCD    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule
